// File: rtl/pwm_nch_dt.sv
// Multi-channel PWM with double-buffered duty, edge/center counting and per-channel deadtime.
// Optional fault latch enabled by defining PWM_FAULT_EN.
module pwm_nch_dt #(
  parameter int WIDTH = 11,
  parameter int NCH   = 3,
  parameter int DT_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 center,
  input  logic [NCH*WIDTH-1:0] duty_in,
  input  logic                 duty_wr,
  input  logic [DT_W-1:0]      dt,
`ifdef PWM_FAULT_EN
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic                 fault_lat,
`endif
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_start
);

  localparam logic [WIDTH-1:0] MAX_C   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
  localparam logic [DT_W-1:0]  DT_ONE_C  = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0]  DT_ZERO_C = {DT_W{1'b0}};

  logic [WIDTH-1:0]           cnt_r, cnt_nxt_s;
  logic                       dir_up_r, dir_up_nxt_s;
  logic                       run_r;
  logic                       mode_act_r;
  logic [NCH*WIDTH-1:0]       shadow_r, duty_act_r;
  logic                       boundary_s;
  logic                       period_start_r;
  logic [NCH-1:0]             raw_s, raw_q_r, hist_r;
  logic [NCH-1:0][DT_W-1:0]   dcnt_r, dcnt_nxt_s;
  logic [NCH-1:0]             hi_nxt_s, lo_nxt_s, pwm_hi_r, pwm_lo_r;
  logic                       restart_s;
  logic                       block_s;

  // Next count: first enabled edge restarts at 0; center mode turns around at MAX and at 1
  always_comb begin
    cnt_nxt_s    = ZERO_C;
    dir_up_nxt_s = 1'b1;
    if (!en || !run_r) begin
      cnt_nxt_s    = ZERO_C;
      dir_up_nxt_s = 1'b1;
    end else if (!mode_act_r) begin
      cnt_nxt_s    = cnt_r + ONE_C;
      dir_up_nxt_s = 1'b1;
    end else if (dir_up_r) begin
      if (cnt_r == MAX_C) begin
        cnt_nxt_s    = MAX_C - ONE_C;
        dir_up_nxt_s = 1'b0;
      end else begin
        cnt_nxt_s    = cnt_r + ONE_C;
        dir_up_nxt_s = 1'b1;
      end
    end else begin
      cnt_nxt_s    = cnt_r - ONE_C;
      dir_up_nxt_s = (cnt_r == ONE_C);
    end
  end

  assign boundary_s = en && (cnt_nxt_s == ZERO_C);

  // Per-channel unsigned compare against the active duty
  always_comb begin
    raw_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      raw_s[i] = run_r && (cnt_r < duty_act_r[i*WIDTH +: WIDTH]);
    end
  end

  // Counter, run flag and double-buffered duty/mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r          <= ZERO_C;
      dir_up_r       <= 1'b1;
      run_r          <= 1'b0;
      mode_act_r     <= 1'b0;
      shadow_r       <= {(NCH*WIDTH){1'b0}};
      duty_act_r     <= {(NCH*WIDTH){1'b0}};
      period_start_r <= 1'b0;
    end else begin
      cnt_r          <= cnt_nxt_s;
      dir_up_r       <= dir_up_nxt_s;
      run_r          <= en;
      period_start_r <= boundary_s;
      if (duty_wr) begin
        shadow_r <= duty_in;
      end
      if (boundary_s) begin
        duty_act_r <= shadow_r;
        mode_act_r <= center;
      end
    end
  end

`ifdef PWM_FAULT_EN
  logic fault_lat_r, clr_pend_r, clr_now_s, fault_lat_nxt_s, clr_pend_nxt_s;

  // Fault latch: set immediately, cleared only on a boundary after a pending clear request
  always_comb begin
    clr_now_s = fault_lat_r && !fault && boundary_s && (clr_pend_r || fault_clr);
    if (fault) begin
      fault_lat_nxt_s = 1'b1;
      clr_pend_nxt_s  = 1'b0;
    end else if (clr_now_s) begin
      fault_lat_nxt_s = 1'b0;
      clr_pend_nxt_s  = 1'b0;
    end else if (fault_lat_r && fault_clr) begin
      fault_lat_nxt_s = 1'b1;
      clr_pend_nxt_s  = 1'b1;
    end else begin
      fault_lat_nxt_s = fault_lat_r;
      clr_pend_nxt_s  = clr_pend_r && fault_lat_r;
    end
  end

  // Fault latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_lat_r <= 1'b0;
      clr_pend_r  <= 1'b0;
    end else begin
      fault_lat_r <= fault_lat_nxt_s;
      clr_pend_r  <= clr_pend_nxt_s;
    end
  end

  assign restart_s = clr_now_s;
  assign block_s   = fault || (fault_lat_r && !clr_now_s);
  assign fault_lat = fault_lat_r;
`else
  assign restart_s = 1'b0;
  assign block_s   = 1'b0;
`endif

  // Deadtime: any raw_q edge (or fault restart) forces both sides low for dt cycles
  always_comb begin
    hi_nxt_s   = {NCH{1'b0}};
    lo_nxt_s   = {NCH{1'b0}};
    dcnt_nxt_s = dcnt_r;
    for (int i = 0; i < NCH; i++) begin
      if (!en || block_s) begin
        dcnt_nxt_s[i] = DT_ZERO_C;
      end else if (restart_s || (raw_q_r[i] != hist_r[i])) begin
        if (dt == DT_ZERO_C) begin
          hi_nxt_s[i]   = raw_q_r[i];
          lo_nxt_s[i]   = !raw_q_r[i];
          dcnt_nxt_s[i] = DT_ZERO_C;
        end else begin
          dcnt_nxt_s[i] = dt - DT_ONE_C;
        end
      end else if (dcnt_r[i] != DT_ZERO_C) begin
        dcnt_nxt_s[i] = dcnt_r[i] - DT_ONE_C;
      end else begin
        hi_nxt_s[i] = raw_q_r[i];
        lo_nxt_s[i] = !raw_q_r[i];
      end
    end
  end

  // Compare pipeline and registered gate-drive outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q_r  <= {NCH{1'b0}};
      hist_r   <= {NCH{1'b0}};
      dcnt_r   <= {(NCH*DT_W){1'b0}};
      pwm_hi_r <= {NCH{1'b0}};
      pwm_lo_r <= {NCH{1'b0}};
    end else begin
      raw_q_r  <= en ? raw_s : {NCH{1'b0}};
      hist_r   <= en ? raw_q_r : {NCH{1'b0}};
      dcnt_r   <= dcnt_nxt_s;
      pwm_hi_r <= hi_nxt_s;
      pwm_lo_r <= lo_nxt_s;
    end
  end

  assign pwm_hi       = pwm_hi_r;
  assign pwm_lo       = pwm_lo_r;
  assign period_start = period_start_r;

endmodule
